mem_io_bridge: RTL and testbench

- Sits between the CPU's external byte bus (address/data/write-enable, 1-cycle read return) and the SoC's 128 KB RAM and UART.
- Decodes RAM versus memory-mapped I/O (addr[17:16]==2'b11).
- Buffers UART output in a TX FIFO, drives the CPU's io_buffer_full back-pressure, serves the UART-input and cycle-counter reads, and runs the program-stop sequence.

---
 rtl/mem_io_bridge.sv | 136 +++++++++++++
 tb/tb_mem_io_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// CPU byte-bus bridge: decodes RAM vs memory-mapped I/O, buffers UART output in a TX FIFO,
// serves UART-input and cycle-counter reads, and sequences the program-stop handshake.
module mem_io_bridge #(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_io_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_empty,
  output logic        uart_rx_pop,
  output logic        prog_done
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(TX_DEPTH - FULL_MARGIN);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SEL_RAM  = 2'd0;
  localparam logic [1:0] SEL_IO   = 2'd1;
  localparam logic [1:0] SEL_ZERO = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  io_q, io_d;
  logic [23:0] snap_q, snap_d;
  logic [31:0] cyc_q;
  logic [AW:0] wptr_q, rptr_q, count;
  logic [7:0]  mem [TX_DEPTH];

  logic       is_io, is_ram;
  logic [2:0] off;
  logic       push, pop, stop_wr;

  assign is_io   = (cpu_a[17:16] == 2'b11);
  assign is_ram  = ~cpu_a[17];
  assign off     = cpu_a[2:0];
  assign count   = wptr_q - rptr_q;
  assign stop_wr = cpu_wr & is_io & (off == 3'd4);

  // Full check uses the pre-pop count, so a simultaneous pop never makes room for a push.
  assign push = rdy_in & cpu_wr & is_io & (off == 3'd0) & (cpu_dout != 8'h00) &
                (count < DEPTH_C) & (state_q == ST_RUN);
  assign pop  = rdy_in & uart_tx_ready & (state_q != ST_EMIT) & (count != '0);

  assign ram_a       = cpu_a[16:0];
  assign ram_wdata   = cpu_dout;
  assign ram_we      = cpu_wr & is_ram & rdy_in & (state_q != ST_DONE);
  assign uart_rx_pop = rdy_in & ~cpu_wr & is_io & (off == 3'd0) & ~uart_rx_empty &
                       (state_q != ST_DONE);

  assign cpu_din       = (sel_q == SEL_RAM) ? ram_rdata : io_q;
  assign cpu_io_full   = (count >= FULL_TH);
  assign uart_tx_valid = (state_q == ST_EMIT) | (count != '0);
  assign uart_tx_data  = (state_q == ST_EMIT) ? 8'h00 : mem[rptr_q[AW-1:0]];
  assign prog_done     = (state_q == ST_DONE);

  always_comb begin
    sel_d  = SEL_ZERO;
    io_d   = 8'h00;
    snap_d = snap_q;
    if (!cpu_wr) begin
      if (is_ram) begin
        sel_d = SEL_RAM;
      end else if (is_io) begin
        sel_d = SEL_IO;
        case (off)
          3'd0: io_d = uart_rx_empty ? 8'h00 : uart_rx_data;
          3'd4: begin
            io_d   = cyc_q[7:0];
            snap_d = cyc_q[31:8];
          end
          3'd5: io_d = snap_q[7:0];
          3'd6: io_d = snap_q[15:8];
          3'd7: io_d = snap_q[23:16];
          default: io_d = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stop_wr) state_d = ST_DRAIN;
      ST_DRAIN: if (count == '0) state_d = ST_EMIT;
      ST_EMIT:  if (uart_tx_ready) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_RUN;
      sel_q   <= SEL_ZERO;
      io_q    <= 8'h00;
      snap_q  <= 24'h0;
      cyc_q   <= 32'h0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (rdy_in) begin
        state_q <= state_d;
        sel_q   <= sel_d;
        io_q    <= io_d;
        snap_q  <= snap_d;
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wptr_q[AW-1:0]] <= cpu_dout;
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: randomized RAM/UART/counter traffic checked against
// queue- and array-based expectations derived from the bridge's documented behaviour.
module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_io_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_empty;
  logic        uart_rx_pop;
  logic        prog_done;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0]  bram [131072];
  logic [7:0]  got [$];
  int          pop_cnt;
  logic [31:0] model_cyc;

  mem_io_bridge #(.TX_DEPTH(16), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_io_full(cpu_io_full), .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_empty(uart_rx_empty), .uart_rx_pop(uart_rx_pop), .prog_done(prog_done)
  );

  always #5 clk_in = ~clk_in;

  // Environment: 1-cycle RAM, UART transmit capture, rx-pop counter, cycle reference.
  always @(posedge clk_in) begin
    if (ram_we) bram[ram_a] <= ram_wdata;
    ram_rdata <= bram[ram_a];
    if (uart_tx_valid && uart_tx_ready && rdy_in) got.push_back(uart_tx_data);
    if (uart_rx_pop) pop_cnt <= pop_cnt + 1;
    model_cyc <= !rst_in ? 32'h0 : model_cyc + 32'd1;
  end

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
  endtask

  task automatic idle();
    drive(32'h0003_0001, 1'b0, 8'h00);
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // Issues a read, then returns cpu_din sampled in the following cycle.
  task automatic do_read(input logic [31:0] a, output logic [7:0] v);
    drive(a, 1'b0, 8'h00);
    step();
    idle();
    @(negedge clk_in);
    v = cpu_din;
    step();
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; uart_tx_ready = 1'b0;
    uart_rx_empty = 1'b1; uart_rx_data = 8'h00;
    idle();
    step(); step();
    @(negedge clk_in);
    tests_run++;
    if ({cpu_din, cpu_io_full, uart_tx_valid, uart_rx_pop, prog_done} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: din=%h full=%b txv=%b rxpop=%b done=%b, want all 0",
               cpu_din, cpu_io_full, uart_tx_valid, uart_rx_pop, prog_done);
    end
    step();
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    logic [16:0] addrs [6];
    logic [7:0]  vals [6];
    logic [7:0]  v;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = (i == 0) ? 17'h00123 : 17'((i * 17'h3A11) ^ $urandom_range(0, 255));
      vals[i]  = (i == 0) ? 8'hAB : 8'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      drive({15'h0, addrs[i]}, 1'b1, vals[i]);
      @(negedge clk_in);
      tests_run++;
      if (ram_we !== 1'b1 || ram_a !== addrs[i] || ram_wdata !== vals[i]) begin
        fails++;
        $display("FAIL ram_write[%0d]: we=%b a=%h d=%h, want we=1 a=%h d=%h",
                 i, ram_we, ram_a, ram_wdata, addrs[i], vals[i]);
      end
      step();
    end
    for (int i = 5; i >= 0; i--) begin
      do_read({15'h0, addrs[i]}, v);
      tests_run++;
      if (v !== vals[i]) begin
        fails++;
        $display("FAIL ram_read[%0d]: got %h want %h", i, v, vals[i]);
      end
    end
    // Unmapped region and rdy_in low both keep the RAM untouched.
    drive(32'h0002_0123, 1'b1, 8'h55);
    @(negedge clk_in);
    tests_run++;
    if (ram_we !== 1'b0) begin
      fails++; $display("FAIL unmapped_we: got %b want 0", ram_we);
    end
    step();
    do_read(32'h0002_0123, v);
    tests_run++;
    if (v !== 8'h00) begin
      fails++; $display("FAIL unmapped_read: got %h want 00", v);
    end
    rdy_in = 1'b0;
    drive(32'h0000_0123, 1'b1, 8'h11);
    @(negedge clk_in);
    tests_run++;
    if (ram_we !== 1'b0) begin
      fails++; $display("FAIL rdy_low_we: got %b want 0", ram_we);
    end
    step();
    rdy_in = 1'b1;
    do_read(32'h0000_0123, v);
    tests_run++;
    if (v !== 8'hAB) begin
      fails++; $display("FAIL rdy_low_hold: got %h want AB", v);
    end
  endtask

  task automatic test_tx_basic();
    logic [7:0] msg [3];
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h00;
    got.delete();
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0003_0000, 1'b1, msg[i]);
      step();
    end
    idle();
    repeat (6) step();
    tests_run++;
    if (got.size() != 2 || got[0] !== 8'h48 || got[1] !== 8'h69) begin
      fails++;
      $display("FAIL tx_basic: got %0d bytes (%h %h), want 2 bytes 48 69", got.size(),
               got.size() > 0 ? got[0] : 8'hxx, got.size() > 1 ? got[1] : 8'hxx);
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] sent [$];
    int         n;
    logic       want_full;
    int         bad;
    got.delete();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(1, 255));
      if (i < 16) sent.push_back(b);
      drive(32'h0003_0000, 1'b1, b);
      @(negedge clk_in);
      n = (i < 16) ? i : 16;
      want_full = (n >= 14);
      tests_run++;
      if (cpu_io_full !== want_full) begin
        fails++;
        $display("FAIL io_full[%0d]: got %b want %b", i, cpu_io_full, want_full);
      end
      step();
    end
    idle();
    uart_tx_ready = 1'b1;
    repeat (24) step();
    bad = (got.size() != 16) ? 1 : 0;
    for (int i = 0; i < 16 && i < got.size(); i++) if (got[i] !== sent[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tx_full_drain: got %0d bytes, %0d wrong, want 16 in order", got.size(), bad);
    end
    tests_run++;
    if (cpu_io_full !== 1'b0 || uart_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_empty_after: full=%b valid=%b want 0 0", cpu_io_full, uart_tx_valid);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] snap;
    logic [7:0]  v;
    logic [7:0]  want;
    // Counter keeps running while rdy_in is low.
    rdy_in = 1'b0;
    repeat (5) step();
    rdy_in = 1'b1;
    snap = model_cyc;
    do_read(32'h0003_0004, v);
    tests_run++;
    if (v !== snap[7:0]) begin
      fails++; $display("FAIL cyc_lo: got %h want %h", v, snap[7:0]);
    end
    for (int k = 1; k <= 3; k++) begin
      repeat ($urandom_range(0, 4)) step();
      do_read(32'h0003_0004 + 32'(k), v);
      want = 8'(snap >> (8 * k));
      tests_run++;
      if (v !== want) begin
        fails++; $display("FAIL cyc_snap_byte%0d: got %h want %h", k - 1, v, want);
      end
    end
  endtask

  task automatic test_rx();
    logic [7:0] rb;
    rb = 8'($urandom_range(1, 255));
    pop_cnt = 0;
    uart_rx_data = rb; uart_rx_empty = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00);
    @(negedge clk_in);
    tests_run++;
    if (uart_rx_pop !== 1'b1) begin
      fails++; $display("FAIL rx_pop_first: got %b want 1", uart_rx_pop);
    end
    step();
    uart_rx_empty = 1'b1; uart_rx_data = 8'h00;
    @(negedge clk_in);
    tests_run++;
    if (cpu_din !== rb || uart_rx_pop !== 1'b0) begin
      fails++;
      $display("FAIL rx_first_data: din=%h pop=%b want %h 0", cpu_din, uart_rx_pop, rb);
    end
    step();
    idle();
    @(negedge clk_in);
    tests_run++;
    if (cpu_din !== 8'h00 || pop_cnt != 1) begin
      fails++;
      $display("FAIL rx_empty_read: din=%h pops=%0d want 00 1", cpu_din, pop_cnt);
    end
    step();
  endtask

  task automatic test_stop();
    logic [7:0] q [3];
    int         waited;
    int         bad;
    got.delete();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q[i] = 8'($urandom_range(1, 255));
      drive(32'h0003_0000, 1'b1, q[i]);
      step();
    end
    drive(32'h0003_0004, 1'b1, 8'($urandom));
    step();
    drive(32'h0003_0000, 1'b1, 8'h77);  // pushes are closed once draining
    step();
    idle();
    uart_tx_ready = 1'b1;
    waited = 0;
    while (prog_done !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    tests_run++;
    if (prog_done !== 1'b1) begin
      fails++; $display("FAIL stop_done: prog_done=%b want 1 within 100 cycles", prog_done);
    end
    bad = (got.size() != 4) ? 1 : 0;
    for (int i = 0; i < 3 && i < got.size(); i++) if (got[i] !== q[i]) bad++;
    if (got.size() == 4 && got[3] !== 8'h00) bad++;
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stop_sequence: got %0d bytes, %0d wrong, want %h %h %h 00",
               got.size(), bad, q[0], q[1], q[2]);
    end
    drive(32'h0000_0456, 1'b1, 8'h99);
    @(negedge clk_in);
    tests_run++;
    if (ram_we !== 1'b0) begin
      fails++; $display("FAIL done_ram_we: got %b want 0", ram_we);
    end
    step();
    drive(32'h0003_0000, 1'b1, 8'h42);
    step();
    idle();
    @(negedge clk_in);
    tests_run++;
    if (uart_tx_valid !== 1'b0 || prog_done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: valid=%b done=%b want 0 1", uart_tx_valid, prog_done);
    end
    step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    @(negedge clk_in);
    tests_run++;
    if (prog_done !== 1'b0) begin
      fails++; $display("FAIL reset_clears_done: got %b want 0", prog_done);
    end
    step();
  endtask

  initial begin
    pop_cnt = 0;
    model_cyc = 32'h0;
    test_reset();
    test_ram();
    test_tx_basic();
    test_tx_full();
    test_counter();
    test_rx();
    test_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
